// File: rtl/wb_pkg.sv
// wb_pkg: shared codes for the write-back stage
package wb_pkg;
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC  = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_FULL = 2'b11;
  typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} halt_state_e;
endpackage

// File: rtl/write_back_stage_if.sv
// write_back_stage_if: MEM/WB inputs and register-bank write port of the write-back stage
interface write_back_stage_if #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int NB_PC   = 32,
  parameter int NB_CNT  = 32
);
  localparam int NB_OFF = $clog2(NB_DATA / 8);
  logic               i_enable;
  logic               i_flush;
  logic               i_valid;
  logic               i_reg_write;
  logic [1:0]         i_result_sel;
  logic [NB_DATA-1:0] i_alu_result;
  logic [NB_DATA-1:0] i_mem_data;
  logic [NB_DATA-1:0] i_imm;
  logic [1:0]         i_mem_size;
  logic               i_mem_unsigned;
  logic [NB_OFF-1:0]  i_byte_offset;
  logic [NB_REG-1:0]  i_selected_reg;
  logic [NB_PC-1:0]   i_pc;
  logic               i_halt;
  logic               i_resume;
  logic               o_valid;
  logic               o_reg_write;
  logic [NB_REG-1:0]  o_selected_reg;
  logic [NB_DATA-1:0] o_selected_data;
  logic               o_halt;
  logic [NB_CNT-1:0]  o_retired;
  modport master (
    output i_enable, i_flush, i_valid, i_reg_write, i_result_sel, i_alu_result, i_mem_data,
           i_imm, i_mem_size, i_mem_unsigned, i_byte_offset, i_selected_reg, i_pc, i_halt, i_resume,
    input  o_valid, o_reg_write, o_selected_reg, o_selected_data, o_halt, o_retired
  );
  modport slave (
    input  i_enable, i_flush, i_valid, i_reg_write, i_result_sel, i_alu_result, i_mem_data,
           i_imm, i_mem_size, i_mem_unsigned, i_byte_offset, i_selected_reg, i_pc, i_halt, i_resume,
    output o_valid, o_reg_write, o_selected_reg, o_selected_data, o_halt, o_retired
  );
endinterface

// File: rtl/load_extend.sv
// load_extend: load lane select with sign/zero extension
module load_extend
  import wb_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_OFF  = $clog2(NB_DATA / 8)
) (
  input  logic [NB_DATA-1:0] i_data,
  input  logic [1:0]         i_size,
  input  logic               i_unsigned,
  input  logic [NB_OFF-1:0]  i_offset,
  output logic [NB_DATA-1:0] o_data
);
  localparam logic [NB_OFF-1:0] M_H = ~NB_OFF'(1);
  logic               sx;
  logic [7:0]         b;
  logic [15:0]        h;
  logic [NB_DATA-1:0] ext_b, ext_h, ext_w;
  assign sx    = ~i_unsigned;
  assign b     = 8'(i_data >> {i_offset, 3'b000});
  assign h     = 16'(i_data >> {i_offset & M_H, 3'b000});
  assign ext_b = {{(NB_DATA-8){sx & b[7]}}, b};
  assign ext_h = {{(NB_DATA-16){sx & h[15]}}, h};
  if (NB_DATA == 32) begin : g_w32
    assign ext_w = i_data;
  end else begin : g_w64
    localparam logic [NB_OFF-1:0] M_W = ~NB_OFF'(3);
    logic [31:0] w;
    assign w     = 32'(i_data >> {i_offset & M_W, 3'b000});
    assign ext_w = {{(NB_DATA-32){sx & w[31]}}, w};
  end
  // pick the extended lane by access size; full width passes through
  always_comb
    o_data = i_size == SZ_BYTE ? ext_b :
             i_size == SZ_HALF ? ext_h :
             i_size == SZ_WORD ? ext_w : i_data;
endmodule

// File: rtl/write_back_stage.sv
// write_back_stage: registered MIPS write-back with load extension, r0 suppression and sticky HALT (WB_RETIRE_CNT_EN adds a retired counter)
module write_back_stage
  import wb_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int NB_PC   = 32,
  parameter int NB_CNT  = 32
) (
  input logic i_clk,
  input logic i_reset_n,
  write_back_stage_if.slave bus
);
  localparam int NB_OFF = $clog2(NB_DATA / 8);
  halt_state_e        state, state_nxt;
  logic               acc;
  logic [NB_DATA-1:0] ld_data, pc_data, res_data;
  assign acc     = bus.i_enable & bus.i_valid & ~bus.i_flush & (state == ST_RUN);
  assign pc_data = NB_DATA'(bus.i_pc);
  load_extend #(.NB_DATA(NB_DATA), .NB_OFF(NB_OFF)) u_load_extend (
    .i_data    (bus.i_mem_data),
    .i_size    (bus.i_mem_size),
    .i_unsigned(bus.i_mem_unsigned),
    .i_offset  (bus.i_byte_offset),
    .o_data    (ld_data)
  );
  // four-way result source select
  always_comb
    res_data = bus.i_result_sel == RES_ALU ? bus.i_alu_result :
               bus.i_result_sel == RES_MEM ? ld_data :
               bus.i_result_sel == RES_PC  ? pc_data : bus.i_imm;
  // MEM/WB boundary register; data and address only move on an accepted instruction
  always_ff @(posedge i_clk)
    if (!i_reset_n) begin
      bus.o_valid         <= 1'b0;
      bus.o_reg_write     <= 1'b0;
      bus.o_selected_reg  <= '0;
      bus.o_selected_data <= '0;
    end else if (bus.i_enable) begin
      bus.o_valid     <= acc;
      bus.o_reg_write <= acc & bus.i_reg_write & (bus.i_selected_reg != '0);
      if (acc) begin
        bus.o_selected_reg  <= bus.i_selected_reg;
        bus.o_selected_data <= res_data;
      end
    end
  // halt state register
  always_ff @(posedge i_clk)
    if (!i_reset_n) state <= ST_RUN;
    else state <= state_nxt;
  // halt next state: enter on an accepted HALT, leave on an enabled resume
  always_comb
    state_nxt = state == ST_RUN ? (acc & bus.i_halt ? ST_HALTED : ST_RUN) :
                (bus.i_resume & bus.i_enable ? ST_RUN : ST_HALTED);
  // halt output follows the registered state
  always_comb bus.o_halt = state == ST_HALTED;
`ifdef WB_RETIRE_CNT_EN
  logic [NB_CNT-1:0] retired;
  // retired-instruction counter, wraps naturally
  always_ff @(posedge i_clk)
    if (!i_reset_n) retired <= '0;
    else if (acc) retired <= retired + 1'b1;
  assign bus.o_retired = retired;
`else
  assign bus.o_retired = '0;
`endif
endmodule
